// File: rtl/tx_control.sv
// tx_control: transmit-side sequencer for the UART calculator.
// Captures the ALU result on a trigger, then hands it byte by byte (LSB
// first) to UART_tx through a start/busy handshake, pulsing done at the end.
module tx_control #(
  parameter int unsigned NBYTES      = 2,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_trigger,
  input  logic [8*NBYTES-1:0]   result,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    FINISH    = 3'd4
  } state_t;

  localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);
  localparam logic [7:0] TO_LAST   = 8'(ACK_TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [8*NBYTES-1:0] shreg, shreg_nxt;
  logic [1:0]          byte_cnt, byte_cnt_nxt;
  logic [7:0]          to_cnt, to_cnt_nxt;
  logic                err_nxt, overrun_nxt;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_cnt <= '0;
      to_cnt   <= '0;
      err      <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      byte_cnt <= byte_cnt_nxt;
      to_cnt   <= to_cnt_nxt;
      err      <= err_nxt;
      overrun  <= overrun_nxt;
    end
  end

  // Next-state logic plus the Mealy start request.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    byte_cnt_nxt = byte_cnt;
    to_cnt_nxt   = to_cnt;
    err_nxt      = err;
    overrun_nxt  = overrun;
    tx_start     = 1'b0;

    // A trigger outside IDLE is dropped but remembered as an overrun.
    if (tx_trigger && (state != IDLE)) begin
      overrun_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (tx_trigger) begin
          shreg_nxt    = result;
          byte_cnt_nxt = '0;
          err_nxt      = 1'b0;
          overrun_nxt  = 1'b0;
          state_nxt    = SEND;
        end
      end

      SEND: begin
        // Hold off while the transmitter is still draining earlier traffic.
        if (!tx_busy) begin
          tx_start   = 1'b1;
          to_cnt_nxt = '0;
          state_nxt  = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_cnt == LAST_BYTE) begin
            state_nxt = FINISH;
          end else begin
            shreg_nxt    = shreg >> 8;
            byte_cnt_nxt = byte_cnt + 2'd1;
            state_nxt    = SEND;
          end
        end
      end

      FINISH: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs decoded directly from the state register.
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == FINISH);
    tx_data = shreg[7:0];
  end

endmodule

// File: tb/tb_tx_control.sv
// tb_tx_control: self-checking bench for tx_control with a behavioural
// UART_tx model and a byte-list reference built from the result value.
module tb_tx_control;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        trig2, trig4;
  logic [15:0] res2;
  logic [31:0] res4;
  logic        tx_busy;
  logic        ext_busy = 1'b0;
  logic        model_busy = 1'b0;

  logic        tx_start2, busy2, done2, overrun2, err2;
  logic [7:0]  tx_data2;
  logic        tx_start4, busy4, done4, overrun4, err4;
  logic [7:0]  tx_data4;

  tx_control #(.NBYTES(2), .ACK_TIMEOUT(16)) u_dut2 (
    .clk(clk), .reset(reset_n), .tx_trigger(trig2), .result(res2),
    .tx_busy(tx_busy), .tx_start(tx_start2), .tx_data(tx_data2),
    .busy(busy2), .done(done2), .overrun(overrun2), .err(err2)
  );

  tx_control #(.NBYTES(4), .ACK_TIMEOUT(16)) u_dut4 (
    .clk(clk), .reset(reset_n), .tx_trigger(trig4), .result(res4),
    .tx_busy(tx_busy), .tx_start(tx_start4), .tx_data(tx_data4),
    .busy(busy4), .done(done4), .overrun(overrun4), .err(err4)
  );

  assign tx_busy = model_busy | ext_busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          last_fall = -100;
  logic [7:0]  sent_q[$];
  int          done2_cnt = 0;
  int          done4_cnt = 0;
  logic        prev_start = 1'b0;
  logic        start_latch = 1'b0;
  bit          ack_en = 1'b1;
  int          ack_dly = 1;
  int          hold = 10;
  int          pending = 0;
  int          busy_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Cycle index: after posedge k the value reads k.
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: logs every byte handed over and checks handshake rules.
  always @(negedge clk) begin
    if (tx_start2 | tx_start4) begin
      check("start_rules", {31'd0, (!prev_start && !tx_busy)}, 32'd1);
      sent_q.push_back(tx_start4 ? tx_data4 : tx_data2);
    end
    prev_start  = tx_start2 | tx_start4;
    start_latch = tx_start2 | tx_start4;
    if (done2) done2_cnt++;
    if (done4) done4_cnt++;
  end

  // UART_tx model: busy rises ack_dly cycles after a start, stays for hold cycles.
  always begin
    logic prev_b;
    @(posedge clk);
    #1;
    if (start_latch && ack_en) pending = ack_dly;
    if (pending > 0) begin
      pending--;
      if (pending == 0) busy_left = hold;
    end
    prev_b     = model_busy;
    model_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    if (prev_b && !model_busy) last_fall = cyc;
  end

  task automatic check_bytes(input string tag, input logic [31:0] res, input int nb);
    logic [7:0] exp_q[$];
    for (int k = 0; k < nb; k++) exp_q.push_back(res[8*k +: 8]);
    check({tag, "/nbytes"}, 32'(sent_q.size()), 32'(nb));
    for (int k = 0; k < nb; k++) begin
      if (k < sent_q.size()) check({tag, "/byte"}, {24'd0, sent_q[k]}, {24'd0, exp_q[k]});
    end
  endtask

  task automatic run_xfer(input bit four, input logic [31:0] res, input int ad, input int hd,
                          input int pre, input bit fin_trig, input string tag);
    int nb;
    bit seen;
    int d0;
    nb      = four ? 4 : 2;
    ack_dly = ad;
    hold    = hd;
    ack_en  = 1'b1;
    sent_q.delete();
    d0 = four ? done4_cnt : done2_cnt;
    ext_busy = (pre > 0);
    if (four) begin res4 = res; trig4 = 1'b1; end
    else      begin res2 = res[15:0]; trig2 = 1'b1; end
    step();
    trig2 = 1'b0;
    trig4 = 1'b0;
    check({tag, "/busy_after_trig"}, {31'd0, (four ? busy4 : busy2)}, 32'd1);
    check({tag, "/start_latency"}, {31'd0, (four ? tx_start4 : tx_start2)}, {31'd0, !tx_busy});
    check({tag, "/err_cleared"}, {31'd0, (four ? err4 : err2)}, 32'd0);
    check({tag, "/ovr_cleared"}, {31'd0, (four ? overrun4 : overrun2)}, 32'd0);
    for (int i = 0; i < pre; i++) begin
      step();
      check({tag, "/held_start"}, {31'd0, (four ? tx_start4 : tx_start2)}, 32'd0);
    end
    ext_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (four ? done4 : done2) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check({tag, "/done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "/done_timing"}, 32'(cyc), 32'(last_fall + 1));
    if (fin_trig) begin
      res2  = 16'h1234;
      trig2 = 1'b1;
    end
    step();
    trig2 = 1'b0;
    check({tag, "/busy_after_done"}, {31'd0, (four ? busy4 : busy2)}, 32'd0);
    check({tag, "/done_single"}, {31'd0, (four ? done4 : done2)}, 32'd0);
    check({tag, "/err"}, {31'd0, (four ? err4 : err2)}, 32'd0);
    check({tag, "/overrun"}, {31'd0, (four ? overrun4 : overrun2)}, {31'd0, fin_trig});
    check({tag, "/done_count"}, 32'((four ? done4_cnt : done2_cnt) - d0), 32'd1);
    if (fin_trig) begin
      repeat (4) step();
      check({tag, "/fin_not_accepted"}, {31'd0, busy2}, 32'd0);
    end
    check_bytes(tag, res, nb);
  endtask

  initial begin
    int d0;
    bit  four;
    reset_n = 1'b0;
    trig2 = 1'b0;
    trig4 = 1'b0;
    res2  = '0;
    res4  = '0;
    repeat (3) step();
    check("rst/tx_start", {31'd0, tx_start2}, 32'd0);
    check("rst/tx_data", {24'd0, tx_data2}, 32'd0);
    check("rst/busy", {31'd0, busy2}, 32'd0);
    check("rst/done", {31'd0, done2}, 32'd0);
    check("rst/overrun", {31'd0, overrun2}, 32'd0);
    check("rst/err", {31'd0, err2}, 32'd0);
    check("rst/busy4", {31'd0, busy4}, 32'd0);
    reset_n = 1'b1;
    step();

    run_xfer(1'b0, 32'h0000BEEF, 1, 10, 0, 1'b0, "basic");
    run_xfer(1'b0, 32'h0000BEEF, 1, 10, 5, 1'b0, "prebusy");

    // Acknowledge timeout: transmitter never answers.
    ack_en = 1'b0;
    sent_q.delete();
    d0 = done2_cnt;
    res2 = 16'hBEEF;
    trig2 = 1'b1;
    step();
    trig2 = 1'b0;
    check("to/start", {31'd0, tx_start2}, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      step();
      check("to/err_low", {31'd0, err2}, 32'd0);
      check("to/busy_high", {31'd0, busy2}, 32'd1);
    end
    step();
    check("to/err_set", {31'd0, err2}, 32'd1);
    check("to/busy_low", {31'd0, busy2}, 32'd0);
    check("to/no_done", 32'(done2_cnt - d0), 32'd0);
    check("to/one_start", 32'(sent_q.size()), 32'd1);
    run_xfer(1'b0, 32'h0000BEEF, 2, 6, 0, 1'b0, "recover");

    // Second trigger mid-transfer must be ignored.
    ack_en = 1'b1;
    ack_dly = 1;
    hold = 10;
    sent_q.delete();
    d0 = done2_cnt;
    res2 = 16'hBEEF;
    trig2 = 1'b1;
    step();
    trig2 = 1'b0;
    for (int i = 0; i < 100 && sent_q.size() == 0; i++) step();
    step();
    res2 = 16'h1234;
    trig2 = 1'b1;
    step();
    trig2 = 1'b0;
    check("ovr/flag", {31'd0, overrun2}, 32'd1);
    check("ovr/busy", {31'd0, busy2}, 32'd1);
    for (int i = 0; i < 200 && !done2; i++) step();
    step();
    check("ovr/sticky", {31'd0, overrun2}, 32'd1);
    check("ovr/done_count", 32'(done2_cnt - d0), 32'd1);
    check_bytes("ovr", 32'h0000BEEF, 2);

    run_xfer(1'b0, 32'h0000C3D2, 1, 4, 0, 1'b1, "fintrig");

    // Reset while byte 0 is being serialized.
    ack_dly = 1;
    hold = 10;
    sent_q.delete();
    res2 = 16'hBEEF;
    trig2 = 1'b1;
    step();
    trig2 = 1'b0;
    for (int i = 0; i < 100 && sent_q.size() == 0; i++) step();
    step();
    step();
    check("rstmid/busy_before", {31'd0, busy2}, 32'd1);
    check("rstmid/data_before", {24'd0, tx_data2}, 32'hEF);
    reset_n = 1'b0;
    #1;
    check("rstmid/tx_start", {31'd0, tx_start2}, 32'd0);
    check("rstmid/tx_data", {24'd0, tx_data2}, 32'd0);
    check("rstmid/busy", {31'd0, busy2}, 32'd0);
    check("rstmid/done", {31'd0, done2}, 32'd0);
    check("rstmid/err", {31'd0, err2}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("rstmid/idle_after", {31'd0, busy2}, 32'd0);
    run_xfer(1'b0, 32'h000000A5, 1, 10, 0, 1'b0, "after_rst");

    run_xfer(1'b1, 32'h01020304, 1, 10, 0, 1'b0, "four");

    for (int i = 0; i < 10; i++) begin
      four = 1'($urandom_range(0, 1));
      run_xfer(four, $urandom, $urandom_range(1, 3), $urandom_range(1, 12),
               $urandom_range(0, 4), 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
